// File: rtl/dot_product_pipe.sv
// Pipelined N-channel unsigned dot product: per-channel multipliers, a registered
// binary adder tree, and a final replace-or-accumulate stage with fixed latency.
module dot_product_pipe #(
    parameter int WIDTH       = 32,
    parameter int N           = 4,
    parameter int MULT_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in [N-1:0],
    input  logic [WIDTH-1:0] w       [N-1:0],
    input  logic             acc_en,
    input  logic             tstart,
    output logic [WIDTH-1:0] out,
    output logic             tout
);

    // Number of nodes on tree level l (level 0 holds the products).
    function automatic int lvl_cnt(input int l);
        int c;
        c = N;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    // Index of the first node of level l in the flattened node array.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += lvl_cnt(k);
        return o;
    endfunction

    function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    localparam int D   = $clog2(N);
    localparam int TOT = lvl_off(D + 1);
    localparam int TN  = (TOT > N) ? (TOT - N) : 1;
    localparam int CD  = MULT_STAGES + D;

    logic [WIDTH-1:0] r_mul_p  [0:MULT_STAGES-1][0:N-1];
    logic [WIDTH-1:0] r_tree_p [0:TN-1];
    logic [WIDTH-1:0] w_node   [0:TOT-1];
    logic [WIDTH-1:0] w_sum;
    logic [CD-1:0]    r_vld_p;
    logic [CD-1:0]    r_acc_p;

    // Multiplier stages: product truncated to WIDTH, then delayed MULT_STAGES-1 more
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MULT_STAGES; s++)
                for (int i = 0; i < N; i++) r_mul_p[s][i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) r_mul_p[0][i] <= data_in[i] * w[i];
            for (int s = 1; s < MULT_STAGES; s++)
                for (int i = 0; i < N; i++) r_mul_p[s][i] <= r_mul_p[s-1][i];
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_leaf
            assign w_node[i] = r_mul_p[MULT_STAGES-1][i];
        end
        for (genvar k = N; k < TOT; k++) begin : g_inner
            assign w_node[k] = r_tree_p[k-N];
        end

        // Adder tree levels: an unpaired last node is registered unchanged
        for (genvar l = 0; l < D; l++) begin : g_lvl
            for (genvar j = 0; j < lvl_cnt(l + 1); j++) begin : g_node
                localparam int SRC = lvl_off(l) + 2 * j;
                localparam int DST = lvl_off(l + 1) - N + j;
                if (2 * j + 1 < lvl_cnt(l)) begin : g_add
                    always_ff @(posedge clk) begin
                        if (rst) r_tree_p[DST] <= '0;
                        else     r_tree_p[DST] <= add_wrap(w_node[SRC], w_node[SRC+1]);
                    end
                end else begin : g_pass
                    always_ff @(posedge clk) begin
                        if (rst) r_tree_p[DST] <= '0;
                        else     r_tree_p[DST] <= w_node[SRC];
                    end
                end
            end
        end
    endgenerate

    assign w_sum = w_node[TOT-1];

    // Valid/accumulate control shift register, aligned with the data stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p <= '0;
            r_acc_p <= '0;
        end else begin
            r_vld_p[0] <= tstart;
            r_acc_p[0] <= acc_en;
            for (int k = 1; k < CD; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
                r_acc_p[k] <= r_acc_p[k-1];
            end
        end
    end

    // Final stage: accumulating onto out itself gives back-to-back ops the prior result
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            tout <= 1'b0;
        end else begin
            tout <= r_vld_p[CD-1];
            if (r_vld_p[CD-1])
                out <= r_acc_p[CD-1] ? add_wrap(out, w_sum) : w_sum;
        end
    end

endmodule

// File: doc/dot_product_pipe.md
DOT_PRODUCT_PIPE -- requirements
Module: dot_product_pipe

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every data, weight and result word; legal range 8..64.
REQ-002 Parameter N, default 4: number of data/weight channel pairs; legal range 1..16.
REQ-003 Parameter MULT_STAGES, default 2: register stages in each multiplier; legal range 1..4.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 out  output  WIDTH: registered result word.
REQ-007 tout  output  1: one-cycle pulse, high in the cycle a new result is on out.
REQ-008 data_in  input  WIDTH x [N-1:0] (unpacked array): channel data, sampled when tstart=1.
REQ-009 w  input  WIDTH x [N-1:0] (unpacked array): channel weights, sampled when tstart=1.
REQ-010 acc_en  input  1: sampled with tstart; 1 means add the sum to the previous out, 0 means replace out.
REQ-011 tstart  input  1: input-valid strobe; one operation accepted per cycle it is high.

Function
REQ-012 Per channel i, compute p[i] = data_in[i]*w[i], unsigned, truncated to the low WIDTH bits.
REQ-013 Multiplier result appears after exactly MULT_STAGES register stages.
REQ-014 Products are reduced by a binary adder tree of D = ceil(log2 N) registered levels; D=0 when N=1.
REQ-015 Odd element count at a tree level: the unpaired element passes through that level's register unchanged.
REQ-016 All additions are modulo 2^WIDTH; carries beyond WIDTH are discarded with no overflow flag.
REQ-017 One final accumulate stage computes the result: acc_en=1 gives out <= out + S; acc_en=0 gives out <= S, where S is the tree sum.
REQ-018 Fixed latency L = MULT_STAGES + D + 1 cycles: tstart high in cycle t gives tout high and a valid out in cycle t+L.
REQ-019 tstart and acc_en travel through an L-deep valid/control shift register aligned with the data pipeline.
REQ-020 Full throughput: tstart may be high every cycle, and each accepted operation produces exactly one tout pulse, in order.
REQ-021 Back-to-back accumulate uses the immediately preceding result: when op k (acc_en=1) completes, the added value is op k-1's out, with no hazard bubble.
REQ-022 When no valid operation reaches the final stage, out holds its value and tout=0.
REQ-023 Data and weight values sampled when tstart=0 do not affect out.
REQ-024 Input data changes while operations are in flight do not alter those operations.
REQ-025 The block has no stall or backpressure; the consumer must accept out in the tout cycle.

Reset
REQ-026 While rst=1 at a clock edge, the following clear to 0: out, tout, every valid/control shift-register bit, and every data pipeline register.
REQ-027 Any operation in flight when rst is asserted is discarded and produces no tout.
REQ-028 rst has priority over tstart arriving in the same cycle; that operation is not accepted.
REQ-029 First cycle after rst deasserts: the block accepts tstart normally.
REQ-030 First cycle after rst deasserts: an acc_en=1 operation accumulates onto out=0.

Verification
REQ-031 Single op, defaults (L=5): data_in={1,2,3,4}, w={5,6,7,8}, acc_en=0, tstart pulse at t0 -> out=70 and tout=1 at t0+5; tout=0 at all other cycles.
REQ-032 Accumulate chain: three back-to-back ops with the REQ-031 inputs, acc_en=0,1,1 -> out=70,140,210 on three consecutive tout cycles.
REQ-033 Wrap-around, WIDTH=8, N=2: data_in={16,255}, w={16,1} -> out=(256+255) mod 256 = 255.
REQ-034 Wrap-around, WIDTH=8, N=2: then acc_en=1 with data_in={1,0}, w={1,0} -> out=0.
REQ-035 Reset mid-flight: tstart at t0 and t0+1, rst=1 at t0+2 for one cycle -> no tout pulses and out=0.
REQ-036 Reset mid-flight: then acc_en=1 op with sum 9 -> out=9.
REQ-037 N=1, MULT_STAGES=1 (L=2): data_in={7}, w={6}, tstart at t0 -> out=42 with tout at t0+2.
REQ-038 Idle hold: with tstart=0 and random data_in/w toggling for 20 cycles, out is stable and tout=0.
REQ-039 N=3 odd tree: data_in={1,1,1}, w={2,3,4} -> out=9 at latency MULT_STAGES+2+1.
